// File: rtl/scope_capture_engine.sv
// Multi-channel scope capture: circular sample buffers, edge trigger with
// pretrigger window, auto/normal/single modes and frame-relative readout.
module scope_capture_engine #(
  parameter int CH_COUNT     = 2,
  parameter int SAMPLE_WIDTH = 12,
  parameter int DEPTH        = 1024,
  parameter int AUTO_TIMEOUT = 4096,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                             Main_CLK,
  input  logic                             Reset,
  input  logic                             Sample_Valid,
  input  logic [CH_COUNT*SAMPLE_WIDTH-1:0] Sample_Data,
  input  logic [CW-1:0]                    Trigger_Channel,
  input  logic [SAMPLE_WIDTH-1:0]          Trigger_Level,
  input  logic                             Trigger_Slope,
  input  logic [1:0]                       Trigger_Mode,
  input  logic [AW-1:0]                    Pretrigger,
  input  logic                             Pause,
  input  logic                             Arm,
  input  logic                             Frame_Ack,
  input  logic [CW-1:0]                    Read_Channel,
  input  logic [AW-1:0]                    Read_Address,
  output logic [SAMPLE_WIDTH-1:0]          Read_Data,
  output logic                             Frame_Ready,
  output logic                             Triggered,
  output logic [1:0]                       State
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(AUTO_TIMEOUT);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    PRE_FILL  = 2'b00,
    WAIT_TRIG = 2'b01,
    POST_FILL = 2'b10,
    HOLD      = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wp_q, wp_d;
  logic [AW-1:0]        tp_q, tp_d;
  logic [AW-1:0]        fs_q, fs_d;
  logic [AW-1:0]        pt_q, pt_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic [CH_COUNT*SW-1:0] prev_q, prev_d;
  logic                 trig_q, trig_d;
  logic [SW-1:0]        rd_q, rd_d;
  logic [SW-1:0]        ram_q [CH_COUNT][DEPTH];

  logic          accept;
  logic          event_hit;
  logic          force_hit;
  logic [CW-1:0] tch;
  logic [CW-1:0] rch;
  logic [SW-1:0] cur_s;
  logic [SW-1:0] prev_s;
  logic [AW:0]   post_len;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] rd_addr;

  always_comb begin
    tch = Trigger_Channel;
    if (int'(Trigger_Channel) >= CH_COUNT) tch = '0;
    rch = Read_Channel;
    if (int'(Read_Channel) >= CH_COUNT) rch = '0;
    cur_s  = Sample_Data[int'(tch)*SW +: SW];
    prev_s = prev_q[int'(tch)*SW +: SW];
    accept = Sample_Valid && !Pause && (state_q != HOLD);
    if (Trigger_Slope)
      event_hit = (prev_s > Trigger_Level) && (cur_s <= Trigger_Level);
    else
      event_hit = (prev_s < Trigger_Level) && (cur_s >= Trigger_Level);
    force_hit = (Trigger_Mode == 2'b00) && (to_q == TO_MAX);
    post_len  = DEPTH_W - {1'b0, pt_q};
    cnt_inc   = cnt_q + (AW + 1)'(1);
    rd_addr   = fs_q + Read_Address;
  end

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    tp_d    = tp_q;
    fs_d    = fs_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    prev_d  = prev_q;
    trig_d  = 1'b0;
    rd_d    = ram_q[rch][rd_addr];
    if (accept) begin
      wp_d   = wp_q + AW'(1);
      prev_d = Sample_Data;
    end
    unique case (state_q)
      PRE_FILL: begin
        if (!Pause && (pt_q == '0)) begin
          state_d = WAIT_TRIG;
          cnt_d   = '0;
          to_d    = '0;
        end else if (accept) begin
          if (cnt_inc == {1'b0, pt_q}) begin
            state_d = WAIT_TRIG;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT_TRIG: begin
        if (accept) begin
          if (event_hit || force_hit) begin
            trig_d = 1'b1;
            tp_d   = wp_q;
            // A full-depth pretrigger leaves only the trigger sample to post-fill
            if (post_len == (AW + 1)'(1)) begin
              state_d = HOLD;
              fs_d    = wp_q - pt_q;
              cnt_d   = '0;
            end else begin
              state_d = POST_FILL;
              cnt_d   = (AW + 1)'(1);
            end
          end else if (to_q != TO_MAX) begin
            to_d = to_q + TW'(1);
          end
        end
      end
      POST_FILL: begin
        if (accept) begin
          if (cnt_inc == post_len) begin
            state_d = HOLD;
            fs_d    = tp_q - pt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (!Pause && ((Trigger_Mode == 2'b10) ? Arm : Frame_Ack)) begin
          state_d = PRE_FILL;
          pt_d    = Pretrigger;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Main_CLK) begin
    if (Reset) begin
      state_q <= PRE_FILL;
      wp_q    <= '0;
      tp_q    <= '0;
      fs_q    <= '0;
      pt_q    <= Pretrigger;
      cnt_q   <= '0;
      to_q    <= '0;
      prev_q  <= '0;
      trig_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      tp_q    <= tp_d;
      fs_q    <= fs_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      prev_q  <= prev_d;
      trig_q  <= trig_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge Main_CLK) begin
    if (accept && !Reset) begin
      for (int c = 0; c < CH_COUNT; c++)
        ram_q[c][wp_q] <= Sample_Data[c*SW +: SW];
    end
  end

  assign Read_Data   = rd_q;
  assign Frame_Ready = (state_q == HOLD);
  assign Triggered   = trig_q;
  assign State       = state_q;

endmodule

// File: tb/tb_scope_capture_engine.sv
// Directed scenarios with random data, checked against a sample-history
// model of the capture engine.
module tb_scope_capture_engine;

  localparam int CH    = 2;
  localparam int SW    = 12;
  localparam int DEPTH = 1024;
  localparam int TO    = 4096;

  logic               clk = 1'b0;
  logic               Reset = 1'b1;
  logic               Sample_Valid = 1'b0;
  logic [CH*SW-1:0]   Sample_Data = '0;
  logic [0:0]         Trigger_Channel = '0;
  logic [SW-1:0]      Trigger_Level = 12'd2048;
  logic               Trigger_Slope = 1'b0;
  logic [1:0]         Trigger_Mode = 2'b01;
  logic [9:0]         Pretrigger = 10'd100;
  logic               Pause = 1'b0;
  logic               Arm = 1'b0;
  logic               Frame_Ack = 1'b0;
  logic [0:0]         Read_Channel = '0;
  logic [9:0]         Read_Address = '0;
  logic [SW-1:0]      Read_Data;
  logic               Frame_Ready;
  logic               Triggered;
  logic [1:0]         State;

  scope_capture_engine #(
    .CH_COUNT(CH), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .AUTO_TIMEOUT(TO)
  ) dut (
    .Main_CLK(clk), .Reset(Reset), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Trigger_Channel(Trigger_Channel),
    .Trigger_Level(Trigger_Level), .Trigger_Slope(Trigger_Slope),
    .Trigger_Mode(Trigger_Mode), .Pretrigger(Pretrigger), .Pause(Pause),
    .Arm(Arm), .Frame_Ack(Frame_Ack), .Read_Channel(Read_Channel),
    .Read_Address(Read_Address), .Read_Data(Read_Data),
    .Frame_Ready(Frame_Ready), .Triggered(Triggered), .State(State)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // every accepted sample since reset, frame start index, pretrigger, trigger index
  logic [SW-1:0] h0[$];
  logic [SW-1:0] h1[$];
  int f0 = 0;
  int pt_m = 100;
  int trig_m = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_hold();
    return (trig_m >= 0) && (h0.size() >= trig_m + DEPTH - pt_m);
  endfunction

  function automatic logic [SW-1:0] gen(input int kind, input int n, input int ch);
    case (kind)
      0: return (ch == 0) ? 12'(n) : 12'($urandom);
      1: return (ch == 0) ? 12'd7 : (((n / 32) % 2 == 0) ? 12'd3000 : 12'd500);
      2: return (ch == 0) ? 12'd100 : 12'($urandom);
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SW-1:0] a, input logic [SW-1:0] b, input bit pz);
    bit exp_t;
    int i;
    logic [SW-1:0] cur, prv;
    exp_t = 1'b0;
    Sample_Valid = 1'b1;
    Sample_Data = {b, a};
    Pause = pz;
    if (!pz && !m_hold()) begin
      i = h0.size();
      cur = Trigger_Channel[0] ? b : a;
      prv = (i == 0) ? 12'd0 : (Trigger_Channel[0] ? h1[i-1] : h0[i-1]);
      h0.push_back(a);
      h1.push_back(b);
      if (trig_m < 0 && i >= f0 + pt_m) begin
        if (Trigger_Slope ? (prv > Trigger_Level && cur <= Trigger_Level)
                          : (prv < Trigger_Level && cur >= Trigger_Level))
          exp_t = 1'b1;
        if (Trigger_Mode == 2'b00 && i - (f0 + pt_m) == TO) exp_t = 1'b1;
        if (exp_t) trig_m = i;
      end
    end
    tick();
    Sample_Valid = 1'b0;
    Pause = 1'b0;
    chk("triggered", 32'(Triggered), 32'(exp_t));
  endtask

  task automatic run_n(input int kind, input int count);
    for (int n = 0; n < count; n++) push(gen(kind, n, 0), gen(kind, n, 1), 1'b0);
  endtask

  task automatic run_to_trig(input int kind, input int budget);
    for (int n = 0; n < budget && trig_m < 0; n++)
      push(gen(kind, n, 0), gen(kind, n, 1), 1'b0);
  endtask

  task automatic run_to_hold(input int kind, input int budget);
    for (int n = 0; n < budget && !m_hold(); n++)
      push(gen(kind, n, 0), gen(kind, n, 1), 1'b0);
    chk("hold_state", 32'(State), 32'd3);
    chk("hold_ready", 32'(Frame_Ready), 32'd1);
  endtask

  task automatic read_at(input int c, input int a, input int exp, input string tag);
    Read_Channel = 1'(c);
    Read_Address = 10'(a);
    tick();
    chk(tag, 32'(Read_Data), 32'(exp));
  endtask

  task automatic check_frame();
    int base;
    if (m_hold()) begin
      base = trig_m - pt_m;
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < DEPTH; a++)
          read_at(c, a, (c == 0) ? int'(h0[base+a]) : int'(h1[base+a]),
                  $sformatf("frame_c%0d_a%0d", c, a));
    end
  endtask

  task automatic do_reset(input logic [9:0] ptv);
    Reset = 1'b1;
    Pretrigger = ptv;
    tick();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_ready", 32'(Frame_Ready), 32'd0);
    chk("rst_trig", 32'(Triggered), 32'd0);
    chk("rst_rdata", 32'(Read_Data), 32'd0);
    Reset = 1'b0;
    Sample_Valid = 1'b0;
    h0.delete();
    h1.delete();
    f0 = 0;
    pt_m = int'(ptv);
    trig_m = -1;
    tick();
    tick();
  endtask

  task automatic restart(input logic [9:0] ptv, input bit use_arm);
    Pretrigger = ptv;
    if (use_arm) Arm = 1'b1;
    else Frame_Ack = 1'b1;
    tick();
    Arm = 1'b0;
    Frame_Ack = 1'b0;
    chk("restart_state", 32'(State), 32'd0);
    chk("restart_ready", 32'(Frame_Ready), 32'd0);
    f0 = h0.size();
    pt_m = int'(ptv);
    trig_m = -1;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ramp, rising, normal mode, pretrigger 100
    do_reset(10'd100);
    run_to_hold(0, 4000);
    read_at(0, 100, 2048, "ramp_addr100");
    read_at(0, 0, 1948, "ramp_addr0");
    check_frame();

    // ack while paused is dropped
    Pause = 1'b1;
    Frame_Ack = 1'b1;
    tick();
    Frame_Ack = 1'b0;
    tick();
    Pause = 1'b0;
    tick();
    chk("paused_ack_state", 32'(State), 32'd3);

    // falling square on ch1
    Trigger_Level = 12'd1000;
    Trigger_Slope = 1'b1;
    Trigger_Channel = 1'b1;
    restart(10'd200, 1'b0);
    run_to_hold(1, 3000);
    read_at(0, 517, 7, "square_ch0_const");
    check_frame();

    // pause for 50 cycles inside post-fill
    Trigger_Level = 12'd2048;
    Trigger_Slope = 1'b0;
    Trigger_Channel = 1'b0;
    restart(10'd300, 1'b0);
    run_to_trig(3, 3000);
    run_n(3, 10);
    for (int k = 0; k < 50; k++) push(12'($urandom), 12'($urandom), 1'b1);
    chk("pause_state", 32'(State), 32'd2);
    run_to_hold(3, 2000);
    check_frame();

    // auto-mode forced trigger after the timeout
    Trigger_Mode = 2'b00;
    restart(10'd0, 1'b0);
    run_n(2, TO);
    chk("auto_wait_state", 32'(State), 32'd1);
    push(12'd100, 12'($urandom), 1'b0);
    chk("auto_post_state", 32'(State), 32'd2);
    run_to_hold(2, 2000);
    check_frame();

    // normal mode, same stimulus, never triggers
    Trigger_Mode = 2'b01;
    restart(10'd0, 1'b0);
    run_n(2, 5000);
    chk("normal_wait_state", 32'(State), 32'd1);
    chk("normal_wait_ready", 32'(Frame_Ready), 32'd0);

    // pretrigger extremes
    do_reset(10'd0);
    chk("pt0_state", 32'(State), 32'd1);
    run_to_hold(3, 3000);
    check_frame();
    restart(10'd1023, 1'b0);
    run_to_hold(3, 5000);
    check_frame();

    // trigger at wp=1020, post-fill wraps the pointer
    Trigger_Level = 12'd1020;
    do_reset(10'd10);
    run_to_hold(0, 3000);
    check_frame();

    // reset during post-fill
    Trigger_Level = 12'd2048;
    restart(10'd50, 1'b0);
    run_to_trig(3, 3000);
    run_n(3, 20);
    chk("pre_reset_state", 32'(State), 32'd2);
    Sample_Valid = 1'b1;
    Sample_Data = 24'($urandom);
    do_reset(10'd5);

    // reset on the same cycle as the trigger sample suppresses the pulse
    Trigger_Level = 12'd50;
    run_n(0, 50);
    chk("pre_trig_state", 32'(State), 32'd1);
    Sample_Valid = 1'b1;
    Sample_Data = {12'd0, 12'd50};
    do_reset(10'd100);

    // single mode: only Arm leaves HOLD
    Trigger_Level = 12'd2048;
    Trigger_Mode = 2'b10;
    run_to_hold(3, 4000);
    check_frame();
    Frame_Ack = 1'b1;
    tick();
    Frame_Ack = 1'b0;
    tick();
    chk("single_ack_state", 32'(State), 32'd3);
    Pause = 1'b1;
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
    Pause = 1'b0;
    tick();
    chk("single_paused_arm", 32'(State), 32'd3);
    restart(10'd100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
